me_control: RTL and testbench
=============================

// Module: me_control
// PURPOSE
//  Sequencer for the full-search motion estimator: 16x16 reference block, 31x31 search window, 16 PEs.
//  Generates reference/search memory addresses, PE clear and mux selects.
//  Also drives the comparator's peready one-hot and vectorx/vectory tags.
//  Sits between the top-level start/done handshake and the PE array + comparator.
//  One search = 256 candidates (16 vertical x 16 horizontal).
// PARAMETERS
//  NPE      16    number of PEs = horizontal candidates per pass (only 16 supported)
//  BLK      16    block edge in pixels (only 16 supported)
//  CNT_W    13    width of master cycle counter cnt (0..4111)
// PORTS
//  clock      in   1    single clock, rising edge
//  resetn     in   1    asynchronous, active-low reset
//  start      in   1    request a new search; sampled in IDLE only
//  busy       out  1    high in RUN/DRAIN
//  done       out  1    one-cycle pulse after final peready
//  compstart  out  1    high while busy; comparator may only update bestdist when high
//  pe_en      out  1    memory data valid to PE array (cnt<4096)
//  addressR   out  8    reference block address = row*16+col
//  addressS1  out  10   search memory address, left half {row[4:0],col[4:0]}
//  addressS2  out  10   search memory address, right half (addressS1+16)
//  s1s2mux    out  16   per-PE select: 1 = use S2 data, 0 = S1
//  newdist    out  16   per-PE accumulator clear/load (one-hot or zero)
//  peready    out  16   one-hot: PE i holds a finished SAD this cycle
//  vectorx    out  4    horizontal candidate index tagged with peready (0..15 = offset -8..+7)
//  vectory    out  4    vertical candidate index tagged with peready
// BEHAVIOUR
//  FSM: IDLE -> RUN on start; RUN -> DRAIN when cnt==4095; DRAIN -> DONE when cnt==4111; DONE -> IDLE.
//  State encoding and cnt are registers; all outputs are decoded from them, with no extra pipeline stage.
//  Reset (any time, incl. mid-run): state=IDLE, cnt=0.
//    All outputs 0; pending search aborted, no done pulse.
//  start in IDLE at edge k: RUN with cnt=0 from edge k+1; cnt += 1 each cycle in RUN/DRAIN.
//  start in RUN/DRAIN/DONE is ignored (not queued).
//  start held high through DONE launches the next search from IDLE one cycle later.
//  In RUN (cnt=0..4095):
//    pe_en=1; addressR=cnt[7:0].
//    row = cnt[11:8]+cnt[7:4] (5-bit, 0..30).
//    addressS1 = row*32 + cnt[3:0]; addressS2 = addressS1 + 16.
//    s1s2mux[i] = (cnt[3:0] < i).
//    newdist[i] = (cnt[7:0]==i), i=0..15.
//  PE i: candidate v starts at cnt=v*256+i and is final at cnt=(v+1)*256+i.
//  peready[i] = (cnt>=256) && (cnt[7:0]==i); peready is never multi-hot and is 0 elsewhere.
//    vectorx = cnt[3:0] when peready!=0, else 0.
//    vectory = cnt[11:8]-1 (4-bit wrap: cnt 4096..4111 -> 15) when peready!=0, else 0.
//  In DRAIN (cnt=4096..4111):
//    pe_en=0; addresses, s1s2mux and newdist = 0.
//    peready/vector decode continues, flushing row v=15.
//  DONE: done=1 for exactly one cycle; busy=compstart=0.
//  Latency: start edge to done high = 4113 cycles; 256 peready pulses per search.
//  Counter never wraps: cnt is held at 0 outside RUN/DRAIN.
// STRUCTURE
//  Shared package me_pkg:
//    NPE, BLK, BLK_PIX=256, RUN_LAST=4095, DRAIN_LAST=4111.
//    State typedef {IDLE, RUN, DRAIN, DONE}.
//  One sub-module, me_addr_gen: combinational cnt -> addressR/S1/S2, s1s2mux.
//  FSM, counter and peready/newdist/vector decode stay in me_control.
// TESTING
//  1 Reset: assert resetn=0 mid-simulation -> all outputs 0 immediately (async), state IDLE.
//  2 Address map: run; at cnt=0x123 -> addressR=0x23, addressS1=99, addressS2=115, s1s2mux=16'hFFF0, newdist=0.
//  3 Tagging: cnt=256 -> peready=16'h0001, vectorx=0, vectory=0.
//    cnt=4111 -> peready=16'h8000, vectorx=15, vectory=15.
//    Count exactly 256 peready pulses, all one-hot.
//  4 Timing: start pulse at edge 0 -> busy from edge 1, done pulse at edge 4113, busy low same cycle.
//    Then pair with comp and random PE SADs: check motionx/motiony against a reference minimum.
//  5 start held high / re-pulsed during RUN -> no restart, cnt monotonic.
//    start held through DONE -> second search begins at edge 4115.
//  6 Reset mid-RUN at cnt=2000, then start -> fresh search from cnt=0; no done from aborted run.

Source files
------------

// File: rtl/me_pkg.sv
// Shared constants and types for the full-search motion estimator sequencer.
// Latency: none (package only).
// Backpressure: none (package only).
package me_pkg;

  localparam int NPE     = 16;    // PEs = horizontal candidates per pass
  localparam int BLK     = 16;    // block edge in pixels
  localparam int BLK_PIX = 256;   // pixels per reference block
  localparam int CNT_W   = 13;    // master cycle counter width (0..4111)

  localparam logic [CNT_W-1:0] RUN_LAST   = 13'd4095;
  localparam logic [CNT_W-1:0] DRAIN_LAST = 13'd4111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } me_state_t;

  // One-hot PE select from a 4-bit PE index.
  function automatic logic [NPE-1:0] pe_onehot(input logic [3:0] idx);
    pe_onehot = {{(NPE-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/me_addr_gen.sv
// Combinational address/select generator: master count -> reference and search
// memory addresses plus per-PE S1/S2 data select.
// Latency: 0 cycles (pure decode). Backpressure: none; outputs forced to 0 when en=0.
//
// Ports:
//   en         in   1   memory data phase active (RUN)
//   cnt        in   12  low bits of the master counter
//   address_r  out  8   reference address = row*16 + col
//   address_s1 out  10  left-half search address {row, 0, col}
//   address_s2 out  10  right-half search address (address_s1 + 16)
//   s1s2mux    out  16  per-PE select, 1 = use S2 data
module me_addr_gen
  import me_pkg::*;
(
  input  logic           en,
  input  logic [11:0]    cnt,
  output logic [7:0]     address_r,
  output logic [9:0]     address_s1,
  output logic [9:0]     address_s2,
  output logic [NPE-1:0] s1s2mux
);

  logic [4:0] row;

  always_comb begin
    // Search row = candidate row (cnt[11:8]) + block row (cnt[7:4]), 0..30.
    row        = {1'b0, cnt[11:8]} + {1'b0, cnt[7:4]};
    address_r  = '0;
    address_s1 = '0;
    address_s2 = '0;
    s1s2mux    = '0;
    if (en) begin
      address_r  = cnt[7:0];
      // The window is 32 words wide, so row*32 + col is a plain concat;
      // the +16 right half only sets bit 4.
      address_s1 = {row, 1'b0, cnt[3:0]};
      address_s2 = {row, 1'b1, cnt[3:0]};
      // PE i is offset i columns to the right: once the column index falls
      // below i, its pixel lives in the right half of the window.
      for (int i = 0; i < NPE; i++) begin
        s1s2mux[i] = ({1'b0, cnt[3:0]} < 5'(i));
      end
    end
  end

endmodule

// File: rtl/me_control.sv
// Sequencer for the 16-PE full-search motion estimator (16x16 block, 31x31 window).
// Latency: start sampled -> done pulse 4113 cycles; all outputs decoded from state/cnt.
// Backpressure: none; start is only accepted in IDLE, ignored otherwise.
//
// Ports:
//   clock, resetn          clock and async active-low reset
//   start                  request a new search (IDLE only)
//   busy / compstart       high in RUN and DRAIN
//   done                   one-cycle pulse after the last peready
//   pe_en                  memory data valid to the PE array
//   addressR/S1/S2         reference and search memory addresses
//   s1s2mux, newdist       per-PE data select and accumulator clear
//   peready, vectorx/y     one-hot finished-SAD strobe with candidate tag
module me_control
  import me_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        compstart,
  output logic        pe_en,
  output logic [7:0]  addressR,
  output logic [9:0]  addressS1,
  output logic [9:0]  addressS2,
  output logic [15:0] s1s2mux,
  output logic [15:0] newdist,
  output logic [15:0] peready,
  output logic [3:0]  vectorx,
  output logic [3:0]  vectory
);

  me_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic run, active, tag_win;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == RUN_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    run       = (state_q == RUN);
    active    = (state_q == RUN) || (state_q == DRAIN);
    busy      = active;
    compstart = active;
    done      = (state_q == DONE);
    pe_en     = run;

    // PE i starts a new candidate at cnt[7:0]==i; clear its accumulator then.
    newdist = '0;
    if (run && (cnt_q[7:4] == 4'd0)) newdist = pe_onehot(cnt_q[3:0]);

    // The same slot one block later marks the previous candidate as final.
    // The first block (cnt<256) has nothing to report yet.
    tag_win = active && (cnt_q >= CNT_W'(BLK_PIX)) && (cnt_q[7:4] == 4'd0);
    peready = '0;
    vectorx = '0;
    vectory = '0;
    if (tag_win) begin
      peready = pe_onehot(cnt_q[3:0]);
      vectorx = cnt_q[3:0];
      // Finished candidate belongs to the previous vertical pass; in DRAIN
      // cnt[11:8] is 0 and the wrap yields row 15.
      vectory = cnt_q[11:8] - 4'd1;
    end
  end

  me_addr_gen u_addr_gen (
    .en         (run),
    .cnt        (cnt_q[11:0]),
    .address_r  (addressR),
    .address_s1 (addressS1),
    .address_s2 (addressS2),
    .s1s2mux    (s1s2mux)
  );

endmodule

// File: tb/tb_me_control.sv
// Self-checking bench for me_control: per-cycle decode checks, a tag scoreboard
// and a behavioural comparator fed with random candidate SADs.
module tb_me_control;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic        busy, done, compstart, pe_en;
  logic [7:0]  addressR;
  logic [9:0]  addressS1, addressS2;
  logic [15:0] s1s2mux, newdist, peready;
  logic [3:0]  vectorx, vectory;
  logic [87:0] all_out;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] vx;
    logic [3:0] vy;
  } tag_t;

  tag_t exp_q[$];
  int   sad_tab[256];

  me_control dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .compstart (compstart),
    .pe_en     (pe_en),
    .addressR  (addressR),
    .addressS1 (addressS1),
    .addressS2 (addressS2),
    .s1s2mux   (s1s2mux),
    .newdist   (newdist),
    .peready   (peready),
    .vectorx   (vectorx),
    .vectory   (vectory)
  );

  assign all_out = {busy, done, compstart, pe_en, addressR, addressS1, addressS2,
                    s1s2mux, newdist, peready, vectorx, vectory};

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    start  = 1'b0;
    #3;
    checks++;
    if (all_out !== 88'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    tick();
    tick();
    resetn = 1'b1;
    tick();
    checks++;
    if (all_out !== 88'd0) begin
      errors++;
      $display("FAIL idle_outputs: got %h want 0", all_out);
    end
  endtask

  // Entry: just after an edge ("edge 0") with the DUT idle.
  task automatic run_search(input bit hold);
    logic [12:0] c;
    logic [4:0]  row;
    logic [9:0]  s1;
    logic [15:0] mux, nd;
    logic        exp_busy, exp_pen, tagw;
    tag_t        t;
    int          pulses;
    int          best_sad, best_x, best_y, ref_idx;

    for (int i = 0; i < 256; i++) sad_tab[i] = int'($urandom_range(100, 60000));
    ref_idx = int'($urandom_range(0, 255));
    sad_tab[ref_idx] = 50;

    exp_q.delete();
    for (int vy = 0; vy < 16; vy++)
      for (int vx = 0; vx < 16; vx++)
        exp_q.push_back({4'(vx), 4'(vy)});

    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_before_start: got %b want 0", busy);
    end

    start    = 1'b1;
    pulses   = 0;
    best_sad = 32'h7fffffff;
    best_x   = -1;
    best_y   = -1;

    for (int n = 1; n <= 4114; n++) begin
      tick();
      if (!hold) start = 1'b0;
      exp_busy = (n <= 4112);
      c        = exp_busy ? 13'(n - 1) : 13'd0;
      exp_pen  = exp_busy && (c < 13'd4096);

      checks++;
      if (busy !== exp_busy || compstart !== exp_busy) begin
        errors++;
        $display("FAIL busy n=%0d: got busy=%b compstart=%b want %b", n, busy, compstart, exp_busy);
      end
      checks++;
      if (done !== (n == 4113)) begin
        errors++;
        $display("FAIL done n=%0d: got %b want %b", n, done, (n == 4113));
      end
      checks++;
      if (pe_en !== exp_pen) begin
        errors++;
        $display("FAIL pe_en n=%0d: got %b want %b", n, pe_en, exp_pen);
      end

      row = 5'd0; s1 = 10'd0; mux = 16'd0; nd = 16'd0;
      if (exp_pen) begin
        row = {1'b0, c[11:8]} + {1'b0, c[7:4]};
        s1  = 10'(int'(row) * 32 + int'(c[3:0]));
        mux = 16'(32'hFFFF << (c[3:0] + 5'd1));
        nd  = (c[7:4] == 4'd0) ? 16'(32'd1 << c[3:0]) : 16'd0;
      end
      checks++;
      if (addressR !== (exp_pen ? c[7:0] : 8'd0) || addressS1 !== s1 ||
          addressS2 !== (exp_pen ? s1 + 10'd16 : 10'd0)) begin
        errors++;
        $display("FAIL addr n=%0d: got R=%0d S1=%0d S2=%0d want S1=%0d", n, addressR, addressS1, addressS2, s1);
      end
      checks++;
      if (s1s2mux !== mux || newdist !== nd) begin
        errors++;
        $display("FAIL mux_newdist n=%0d: got %h/%h want %h/%h", n, s1s2mux, newdist, mux, nd);
      end

      tagw = exp_busy && (c >= 13'd256) && (c[7:4] == 4'd0);
      if (tagw) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tag_underflow n=%0d: got pulse want none queued", n);
        end else begin
          t = exp_q.pop_front();
          if (peready !== 16'(32'd1 << t.vx) || vectorx !== t.vx || vectory !== t.vy) begin
            errors++;
            $display("FAIL tag n=%0d: got pr=%h x=%0d y=%0d want x=%0d y=%0d", n, peready, vectorx, vectory, t.vx, t.vy);
          end
        end
      end else begin
        checks++;
        if ({peready, vectorx, vectory} !== 24'd0) begin
          errors++;
          $display("FAIL tag_idle n=%0d: got pr=%h x=%0d y=%0d want 0", n, peready, vectorx, vectory);
        end
      end

      if (peready != 16'd0) begin
        pulses++;
        checks++;
        if (!$onehot(peready)) begin
          errors++;
          $display("FAIL onehot n=%0d: got %h want one-hot", n, peready);
        end
        if (compstart && sad_tab[int'(vectory) * 16 + int'(vectorx)] < best_sad) begin
          best_sad = sad_tab[int'(vectory) * 16 + int'(vectorx)];
          best_x   = int'(vectorx);
          best_y   = int'(vectory);
        end
      end

      if (exp_busy && c == 13'h123) begin
        checks++;
        if (addressR !== 8'h23 || addressS1 !== 10'd99 || addressS2 !== 10'd115 ||
            s1s2mux !== 16'hFFF0 || newdist !== 16'h0000) begin
          errors++;
          $display("FAIL addr_0x123: got R=%h S1=%0d S2=%0d mux=%h nd=%h want 23/99/115/fff0/0",
                   addressR, addressS1, addressS2, s1s2mux, newdist);
        end
      end
      if (exp_busy && c == 13'd256) begin
        checks++;
        if (peready !== 16'h0001 || vectorx !== 4'd0 || vectory !== 4'd0) begin
          errors++;
          $display("FAIL tag_256: got pr=%h x=%0d y=%0d want 0001/0/0", peready, vectorx, vectory);
        end
      end
      if (exp_busy && c == 13'd4111) begin
        checks++;
        if (peready !== 16'h8000 || vectorx !== 4'd15 || vectory !== 4'd15) begin
          errors++;
          $display("FAIL tag_4111: got pr=%h x=%0d y=%0d want 8000/15/15", peready, vectorx, vectory);
        end
      end
    end

    checks++;
    if (pulses != 256) begin
      errors++;
      $display("FAIL pulse_count: got %0d want 256", pulses);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL tags_left: got %0d unconsumed want 0", exp_q.size());
    end
    checks++;
    if (best_x != ref_idx % 16 || best_y != ref_idx / 16) begin
      errors++;
      $display("FAIL motion: got x=%0d y=%0d want x=%0d y=%0d", best_x, best_y, ref_idx % 16, ref_idx / 16);
    end

    if (hold) begin
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || pe_en !== 1'b1 || addressR !== 8'd0) begin
        errors++;
        $display("FAIL restart_4115: got busy=%b pe_en=%b R=%0d want 1/1/0", busy, pe_en, addressR);
      end
    end
  endtask

  task automatic test_full_search();
    run_search(1'b0);
  endtask

  task automatic test_start_held();
    run_search(1'b1);
  endtask

  // Entry: second search running with cnt=0.
  task automatic test_reset_mid_run();
    for (int k = 1; k <= 2000; k++) begin
      tick();
      start = (k == 500);
      checks++;
      if (addressR !== 8'(k) || busy !== 1'b1) begin
        errors++;
        $display("FAIL monotonic k=%0d: got R=%0d busy=%b want R=%0d busy=1", k, addressR, busy, 8'(k));
      end
    end
    checks++;
    if (addressR !== 8'hD0) begin
      errors++;
      $display("FAIL cnt_2000: got R=%h want d0", addressR);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (all_out !== 88'd0) begin
      errors++;
      $display("FAIL async_reset: got %h want 0", all_out);
    end
    tick();
    resetn = 1'b1;
    for (int k = 0; k < 2300; k++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL aborted_run k=%0d: got done=%b busy=%b want 0/0", k, done, busy);
      end
    end
    run_search(1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    test_reset();
    test_full_search();
    test_start_held();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
